alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares one combinational 32-bit ALU among NUM_REQ requesters (shader lanes / warp slots) using round-robin arbitration.
- Each requester uses a valid/ready request handshake and receives its result through a single tagged, valid/ready response port.
- The block registers the winning operation, drives the ALU, captures the ALU result and status flags, and returns them tagged with the requester ID.
- One operation is in flight at a time; peak throughput is one operation every 2 cycles.

Parameters:
- NUM_REQ, 4, number of requesters; power of two, 2..8.
- DATA_W, 32, operand and result width.
- ID_W, 2, requester-ID width; equals log2(NUM_REQ).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept strobe; one-hot or zero.
- req_op  in  4*NUM_REQ  flattened ALU opcodes; requester i uses bits [4i+3:4i].
- req_a  in  DATA_W*NUM_REQ  flattened operand A per requester, signed.
- req_b  in  DATA_W*NUM_REQ  flattened operand B per requester, signed.
- alu_ctrl  out  4  opcode driven to the ALU.
- alu_a  out  DATA_W  operand A driven to the ALU.
- alu_b  out  DATA_W  operand B driven to the ALU.
- alu_res  in  DATA_W  ALU result.
- alu_flags  in  5  ALU flags {isLT, isGT, isEqual, isNegative, isZero}.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_res  out  DATA_W  captured result.
- rsp_flags  out  5  captured flags, same bit order as alu_flags.
- rsp_illegal  out  1  opcode was greater than 9 (outside the defined ALU opcode set).

Behaviour:
- States: IDLE, EXEC, RESP. The state register resets to IDLE.
- Reset values:
  - req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_res = 0, rsp_flags = 0, rsp_illegal = 0.
  - alu_ctrl/alu_a/alu_b registers = 0; the round-robin pointer = 0.
- Accept: a request is accepted in any cycle where the block is in IDLE, or in RESP with rsp_ready=1, and req_valid has at least one bit set.
  - In that cycle the block asserts combinational req_ready[g] for the grant g only.
  - On the clock edge it latches req_op[g], req_a[g], req_b[g] into the alu_* registers and g into the ID register, then moves to EXEC.
- Round-robin:
  - Priority search starts at the pointer and wraps modulo NUM_REQ; the first asserted req_valid wins.
  - On accept, the pointer becomes (g+1) mod NUM_REQ.
  - The pointer holds when nothing is accepted.
- EXEC (exactly 1 cycle):
  - alu_* outputs are stable from registers.
  - On the clock edge: rsp_res <= alu_res, rsp_flags <= alu_flags, rsp_illegal <= (alu_ctrl > 9), rsp_valid <= 1; move to RESP.
- RESP:
  - rsp_* outputs are held stable while rsp_valid=1 and rsp_ready=0.
  - Response transfers when rsp_valid and rsp_ready are both 1.
  - After transfer: go to EXEC if a new request is accepted in the same cycle, otherwise go to IDLE with rsp_valid=0.
- Latency: 2 cycles from the accept edge to rsp_valid.
- req_valid is allowed to drop before acceptance; the arbiter samples it only in accepting cycles, and a dropped request is never granted.
- Illegal opcodes (10..15) are forwarded to the ALU unchanged; the response is still produced, and rsp_illegal=1 marks it.
- Reset mid-operation discards the in-flight operation with no response and returns the block to IDLE with the pointer at 0.
- alu_* outputs hold their last value in IDLE and RESP; they do not toggle without an accept.

Decomposition:
- Package alu_pkg:
  - Opcode constants: ADD=0, SUB=1, SL=2, SR=3, AND=4, OR=5, XOR=6, NAND=7, NOT=8, NOR=9.
  - OP_MAX=9.
  - Flag bit indices: ZERO=0, NEG=1, EQ=2, GT=3, LT=4.
  - State enum.
- Sub-module rr_picker:
  - Combinational; inputs are the request vector and the pointer.
  - Outputs are a one-hot grant and the encoded grant index.

Test Plan:
1. Single request: only req 2 valid, op=ADD, A=5, B=7, ALU returns 12 → req_ready[2] high for one cycle; 2 cycles later rsp_valid=1, rsp_id=2, rsp_res=12, rsp_flags[LT]=1, rsp_illegal=0.
2. Fairness: all 4 requesters held valid, rsp_ready=1 continuously → grant order is 0,1,2,3,0,…; one accept every 2 cycles.
3. Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_* held constant, req_ready all 0; release rsp_ready → one transfer, then the next grant in the same cycle.
4. Illegal op: req 1 issues op=12 → response carries rsp_illegal=1 and rsp_id=1; the next request proceeds normally.
5. Reset mid-EXEC: assert rst while in EXEC → next cycle rsp_valid=0, state IDLE, and the first grant after reset goes to req 0 with all requesters valid.
6. Retracted request: req 3 valid only during a cycle in RESP with rsp_ready=0 → req 3 never granted and no response with rsp_id=3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Contents:
//   - opcode constants of the shared ALU (ADD..NOR) and OP_MAX
//   - bit positions inside the 5-bit flag vector {LT, GT, EQ, NEG, ZERO}
//   - arbiter FSM state encoding
//   - is_illegal(): true for opcodes outside the defined ALU set
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_SL   = 4'd2;
  localparam logic [3:0] OP_SR   = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NAND = 4'd7;
  localparam logic [3:0] OP_NOT  = 4'd8;
  localparam logic [3:0] OP_NOR  = 4'd9;
  localparam logic [3:0] OP_MAX  = OP_NOR;

  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_EQ   = 2;
  localparam int FLAG_GT   = 3;
  localparam int FLAG_LT   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op > OP_MAX);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters and the ALU arbiter.
// Signals:
//   req_valid/req_ready  per-requester handshake (req_ready one-hot or zero)
//   req_op/req_a/req_b   flattened per-requester opcode and operands
//   rsp_valid/rsp_ready  single tagged response handshake
//   rsp_id/rsp_res/rsp_flags/rsp_illegal  response payload
// Modports:
//   master  requester / response-consumer side
//   slave   arbiter side
interface alu_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [4*NUM_REQ-1:0]      req_op;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;

  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_res;
  logic [4:0]                rsp_flags;
  logic                      rsp_illegal;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_illegal
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_res, rsp_flags, rsp_illegal
  );

endinterface

// File: rtl/alu_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Ports:
//   req        request vector
//   ptr        index where the priority search starts
//   grant      one-hot grant (zero when no request)
//   grant_idx  encoded index of the granted requester (0 when no request)
// The search wraps modulo NUM_REQ; NUM_REQ must equal 2**ID_W so the
// wrap is a plain ID_W-bit overflow.
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_idx
);

  always_comb begin
    logic            found;
    logic [ID_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ptr + ID_W'(k);
      if (!found && req[idx]) begin
        found          = 1'b1;
        grant[idx]     = 1'b1;
        grant_idx      = idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NUM_REQ requesters.
// Ports:
//   clk, rst      clock (rising edge) and synchronous active-high reset
//   bus           alu_arbiter_if slave: request handshakes and tagged response
//   alu_ctrl/a/b  registered opcode and operands driven to the ALU
//   alu_res       ALU result, captured one cycle after accept
//   alu_flags     ALU flags {LT, GT, EQ, NEG, ZERO}, captured with alu_res
// Flow: IDLE -> (accept) EXEC -> RESP -> (transfer) IDLE, or straight back
// to EXEC when a new request is accepted in the transfer cycle, giving one
// operation every two cycles at best.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int ID_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output logic [3:0]        alu_ctrl,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [4:0]        alu_flags
);

  state_t state_reg, state_next;

  logic [ID_W-1:0]    ptr_reg;
  logic [ID_W-1:0]    id_reg;
  logic [3:0]         ctrl_reg;
  logic [DATA_W-1:0]  a_reg;
  logic [DATA_W-1:0]  b_reg;

  logic [ID_W-1:0]    rsp_id_reg;
  logic [DATA_W-1:0]  rsp_res_reg;
  logic [4:0]         rsp_flags_reg;
  logic               rsp_illegal_reg;

  logic [NUM_REQ-1:0] grant_oh;
  logic [ID_W-1:0]    grant_idx;
  logic               accept;

  // Unflattened per-requester views of the request payload.
  logic [3:0]         op_arr [NUM_REQ];
  logic [DATA_W-1:0]  a_arr  [NUM_REQ];
  logic [DATA_W-1:0]  b_arr  [NUM_REQ];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_arr[gi] = bus.req_op[4*gi +: 4];
      assign a_arr[gi]  = bus.req_a[DATA_W*gi +: DATA_W];
      assign b_arr[gi]  = bus.req_b[DATA_W*gi +: DATA_W];
    end
  endgenerate

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req       (bus.req_valid),
    .ptr       (ptr_reg),
    .grant     (grant_oh),
    .grant_idx (grant_idx)
  );

  // A slot opens when idle, or when the pending response leaves this cycle.
  // Gated by rst so no grant strobe is seen while reset is held.
  always_comb begin
    accept = 1'b0;
    if (!rst && (|bus.req_valid)) begin
      accept = (state_reg == ST_IDLE) ||
               ((state_reg == ST_RESP) && bus.rsp_ready);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = ST_EXEC;
      end
      ST_EXEC: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        if (bus.rsp_ready) state_next = accept ? ST_EXEC : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    if (accept) bus.req_ready = grant_oh;
    if (state_reg == ST_RESP) bus.rsp_valid = 1'b1;
  end

  // Operation registers, pointer and response capture. The response
  // payload has its own registers so a back-to-back accept in the transfer
  // cycle cannot disturb what the consumer is reading.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg         <= '0;
      id_reg          <= '0;
      ctrl_reg        <= '0;
      a_reg           <= '0;
      b_reg           <= '0;
      rsp_id_reg      <= '0;
      rsp_res_reg     <= '0;
      rsp_flags_reg   <= '0;
      rsp_illegal_reg <= 1'b0;
    end else begin
      if (accept) begin
        ctrl_reg <= op_arr[grant_idx];
        a_reg    <= a_arr[grant_idx];
        b_reg    <= b_arr[grant_idx];
        id_reg   <= grant_idx;
        ptr_reg  <= grant_idx + 1'b1;
      end
      if (state_reg == ST_EXEC) begin
        rsp_id_reg      <= id_reg;
        rsp_res_reg     <= alu_res;
        rsp_flags_reg   <= alu_flags;
        rsp_illegal_reg <= is_illegal(ctrl_reg);
      end
    end
  end

  assign alu_ctrl        = ctrl_reg;
  assign alu_a           = a_reg;
  assign alu_b           = b_reg;
  assign bus.rsp_id      = rsp_id_reg;
  assign bus.rsp_res     = rsp_res_reg;
  assign bus.rsp_flags   = rsp_flags_reg;
  assign bus.rsp_illegal = rsp_illegal_reg;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single request, round-robin fairness,
// backpressure with a retracted request, illegal opcode, reset mid-EXEC.
// A small combinational ALU model answers the DUT's ALU port.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int ID_W    = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [3:0]        alu_ctrl;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_res;
  logic [4:0]        alu_flags;

  logic [3:0]        op_arr [NUM_REQ];
  logic [DATA_W-1:0] a_arr  [NUM_REQ];
  logic [DATA_W-1:0] b_arr  [NUM_REQ];

  int checks = 0;
  int errors = 0;

  alu_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) bus ();

  alu_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .alu_ctrl  (alu_ctrl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_res   (alu_res),
    .alu_flags (alu_flags)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      bus.req_op[4*i +: 4]        = op_arr[i];
      bus.req_a[DATA_W*i +: DATA_W] = a_arr[i];
      bus.req_b[DATA_W*i +: DATA_W] = b_arr[i];
    end
  end

  // Reference ALU
  always_comb begin
    alu_res = '0;
    case (alu_ctrl)
      OP_ADD:  alu_res = alu_a + alu_b;
      OP_SUB:  alu_res = alu_a - alu_b;
      OP_SL:   alu_res = alu_a << alu_b[4:0];
      OP_SR:   alu_res = alu_a >> alu_b[4:0];
      OP_AND:  alu_res = alu_a & alu_b;
      OP_OR:   alu_res = alu_a | alu_b;
      OP_XOR:  alu_res = alu_a ^ alu_b;
      OP_NAND: alu_res = ~(alu_a & alu_b);
      OP_NOT:  alu_res = ~alu_a;
      OP_NOR:  alu_res = ~(alu_a | alu_b);
      default: alu_res = '0;
    endcase
    alu_flags            = '0;
    alu_flags[FLAG_ZERO] = (alu_res == '0);
    alu_flags[FLAG_NEG]  = alu_res[DATA_W-1];
    alu_flags[FLAG_EQ]   = (alu_a == alu_b);
    alu_flags[FLAG_GT]   = ($signed(alu_a) > $signed(alu_b));
    alu_flags[FLAG_LT]   = ($signed(alu_a) < $signed(alu_b));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_arr[i] = OP_ADD;
      a_arr[i]  = '0;
      b_arr[i]  = '0;
    end

    // Reset state
    cyc();
    cyc();
    settle();
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_res", 64'(bus.rsp_res), 64'd0);
    chk("rst_rsp_flags", 64'(bus.rsp_flags), 64'd0);
    chk("rst_rsp_illegal", 64'(bus.rsp_illegal), 64'd0);
    chk("rst_alu_ctrl", 64'(alu_ctrl), 64'd0);
    chk("rst_alu_a", 64'(alu_a), 64'd0);
    chk("rst_alu_b", 64'(alu_b), 64'd0);
    rst = 1'b0;
    cyc();
    $display("reset: checks so far %0d", checks);

    // 1. Single request from requester 2: 5 + 7
    op_arr[2] = OP_ADD;
    a_arr[2]  = 32'd5;
    b_arr[2]  = 32'd7;
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b1;
    settle();
    chk("t1_req_ready", 64'(bus.req_ready), 64'h4);
    cyc();
    bus.req_valid = '0;
    settle();
    chk("t1_exec_req_ready", 64'(bus.req_ready), 64'd0);
    chk("t1_exec_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t1_alu_a", 64'(alu_a), 64'd5);
    chk("t1_alu_b", 64'(alu_b), 64'd7);
    cyc();
    chk("t1_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t1_rsp_id", 64'(bus.rsp_id), 64'd2);
    chk("t1_rsp_res", 64'(bus.rsp_res), 64'd12);
    chk("t1_rsp_flags", 64'(bus.rsp_flags), 64'h10);
    chk("t1_rsp_illegal", 64'(bus.rsp_illegal), 64'd0);
    cyc();
    chk("t1_idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    $display("single request: id 2 res 12 done");

    // 2. Fairness from a fresh pointer: all requesters valid, consumer always ready
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      op_arr[i] = OP_ADD;
      a_arr[i]  = 32'(100 + i);
      b_arr[i]  = 32'(i);
    end
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("t2_grant", 64'(bus.req_ready), 64'(1 << (k % 4)));
      cyc();
      chk("t2_exec_req_ready", 64'(bus.req_ready), 64'd0);
      cyc();
      chk("t2_rsp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("t2_rsp_id", 64'(bus.rsp_id), 64'(k % 4));
      chk("t2_rsp_res", 64'(bus.rsp_res), 64'(100 + 2 * (k % 4)));
      chk("t2_rsp_flags", 64'(bus.rsp_flags), 64'h08);
      $display("fairness: transaction %0d id %0d res %0d", k, bus.rsp_id, bus.rsp_res);
    end

    // 3 + 6. Backpressure on the response for id 3; requester 3 raises
    // valid for one stalled cycle only and must never be granted.
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    settle();
    chk("t3_stall_req_ready", 64'(bus.req_ready), 64'd0);
    for (int c = 0; c < 5; c++) begin
      cyc();
      bus.req_valid = (c == 1) ? 4'b1000 : 4'b0000;
      settle();
      chk("t3_hold_valid", 64'(bus.rsp_valid), 64'd1);
      chk("t3_hold_id", 64'(bus.rsp_id), 64'd3);
      chk("t3_hold_res", 64'(bus.rsp_res), 64'd106);
      chk("t3_hold_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.req_valid = 4'b0001;
    bus.rsp_ready = 1'b1;
    settle();
    chk("t3_release_grant", 64'(bus.req_ready), 64'h1);
    cyc();
    bus.req_valid = '0;
    settle();
    chk("t3_after_xfer_valid", 64'(bus.rsp_valid), 64'd0);
    cyc();
    chk("t3_next_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t6_next_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("t3_next_rsp_res", 64'(bus.rsp_res), 64'd100);
    $display("backpressure: held 5 cycles, next id %0d", bus.rsp_id);

    // 4. Illegal opcode 12 from requester 1, then a normal SUB from requester 2
    op_arr[1] = 4'd12;
    a_arr[1]  = 32'd3;
    b_arr[1]  = 32'd3;
    bus.req_valid = 4'b0010;
    settle();
    chk("t4_grant", 64'(bus.req_ready), 64'h2);
    cyc();
    bus.req_valid = '0;
    settle();
    chk("t4_alu_ctrl", 64'(alu_ctrl), 64'd12);
    cyc();
    chk("t4_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t4_rsp_illegal", 64'(bus.rsp_illegal), 64'd1);
    chk("t4_rsp_id", 64'(bus.rsp_id), 64'd1);
    chk("t4_rsp_res", 64'(bus.rsp_res), 64'd0);
    chk("t4_rsp_flags", 64'(bus.rsp_flags), 64'h05);
    $display("illegal op: id %0d illegal %0d", bus.rsp_id, bus.rsp_illegal);
    op_arr[2] = OP_SUB;
    a_arr[2]  = 32'd3;
    b_arr[2]  = 32'd10;
    bus.req_valid = 4'b0100;
    settle();
    chk("t4_next_grant", 64'(bus.req_ready), 64'h4);
    cyc();
    bus.req_valid = '0;
    cyc();
    chk("t4_sub_rsp_id", 64'(bus.rsp_id), 64'd2);
    chk("t4_sub_rsp_res", 64'(bus.rsp_res), 64'hFFFF_FFF9);
    chk("t4_sub_rsp_flags", 64'(bus.rsp_flags), 64'h12);
    chk("t4_sub_rsp_illegal", 64'(bus.rsp_illegal), 64'd0);
    cyc();
    chk("t4_idle_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    $display("normal op after illegal: res %0h", bus.rsp_res);

    // 5. Reset while in EXEC (pointer is 3 here)
    bus.req_valid = 4'b1111;
    settle();
    chk("t5_pre_grant", 64'(bus.req_ready), 64'h8);
    cyc();
    rst = 1'b1;
    cyc();
    chk("t5_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t5_rst_req_ready", 64'(bus.req_ready), 64'd0);
    cyc();
    chk("t5_rst_rsp_valid2", 64'(bus.rsp_valid), 64'd0);
    rst = 1'b0;
    settle();
    chk("t5_first_grant", 64'(bus.req_ready), 64'h1);
    cyc();
    bus.req_valid = '0;
    cyc();
    chk("t5_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("t5_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("t5_rsp_res", 64'(bus.rsp_res), 64'd100);
    $display("reset mid-exec: first grant id %0d", bus.rsp_id);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
